// File: rtl/video_timing_gen.sv
// Video timing generator: programmable sync/porch/active raster with
// registered sync, data-enable, active coordinates and a frame-boundary
// mode-change handshake.
module video_timing_gen #(
  parameter int X_BITS = 12,
  parameter int Y_BITS = 12,
  parameter int H_SYNC = 44,
  parameter int H_BP   = 148,
  parameter int H_ACT  = 1920,
  parameter int H_FP   = 88,
  parameter int V_SYNC = 5,
  parameter int V_BP   = 36,
  parameter int V_ACT  = 1080,
  parameter int V_FP   = 4,
  parameter bit HS_POL = 1'b1,
  parameter bit VS_POL = 1'b1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              en,
  input  logic              cfg_valid,
  input  logic [X_BITS-1:0] cfg_h_sync,
  input  logic [X_BITS-1:0] cfg_h_bp,
  input  logic [X_BITS-1:0] cfg_h_act,
  input  logic [X_BITS-1:0] cfg_h_fp,
  input  logic [Y_BITS-1:0] cfg_v_sync,
  input  logic [Y_BITS-1:0] cfg_v_bp,
  input  logic [Y_BITS-1:0] cfg_v_act,
  input  logic [Y_BITS-1:0] cfg_v_fp,
  input  logic              cfg_hs_pol,
  input  logic              cfg_vs_pol,
  output logic              cfg_ack,
  output logic              cfg_err,
  output logic              hs_out,
  output logic              vs_out,
  output logic              de_out,
  output logic [X_BITS-1:0] x_act,
  output logic [Y_BITS-1:0] y_act,
  output logic              frame_start,
  output logic              line_start
);

  // Request totals get two guard bits so four maximal fields cannot wrap.
  localparam int XW = X_BITS + 2;
  localparam int YW = Y_BITS + 2;
  localparam logic [XW-1:0] H_MAX = {2'b00, {X_BITS{1'b1}}};
  localparam logic [YW-1:0] V_MAX = {2'b00, {Y_BITS{1'b1}}};

  logic [X_BITS-1:0] h_cnt, h_sync, h_bp, h_act, h_fp;
  logic [Y_BITS-1:0] v_cnt, v_sync, v_bp, v_act, v_fp;
  logic              hs_pol, vs_pol;

  logic [X_BITS-1:0] p_h_sync, p_h_bp, p_h_act, p_h_fp;
  logic [Y_BITS-1:0] p_v_sync, p_v_bp, p_v_act, p_v_fp;
  logic              p_hs_pol, p_vs_pol, pend;

  logic [X_BITS-1:0] h_total, h_start, h_end;
  logic [Y_BITS-1:0] v_total, v_start, v_end;
  logic [XW-1:0]     cfg_h_total;
  logic [YW-1:0]     cfg_v_total;
  logic              h_last, v_last, frame_end, apply, cfg_ok, h_in, v_in;

  // Raster geometry of the active mode and validation of incoming requests.
  always_comb begin
    h_total     = h_sync + h_bp + h_act + h_fp;
    v_total     = v_sync + v_bp + v_act + v_fp;
    h_start     = h_sync + h_bp;
    v_start     = v_sync + v_bp;
    h_end       = h_start + h_act;
    v_end       = v_start + v_act;
    h_last      = (h_cnt == h_total - X_BITS'(1));
    v_last      = (v_cnt == v_total - Y_BITS'(1));
    frame_end   = en && h_last && v_last;
    apply       = pend && (frame_end || !en);
    h_in        = (h_cnt >= h_start) && (h_cnt < h_end);
    v_in        = (v_cnt >= v_start) && (v_cnt < v_end);
    cfg_h_total = XW'(cfg_h_sync) + XW'(cfg_h_bp) + XW'(cfg_h_act) + XW'(cfg_h_fp);
    cfg_v_total = YW'(cfg_v_sync) + YW'(cfg_v_bp) + YW'(cfg_v_act) + YW'(cfg_v_fp);
    cfg_ok      = (cfg_h_sync != '0) && (cfg_h_act != '0) &&
                  (cfg_v_sync != '0) && (cfg_v_act != '0) &&
                  (cfg_h_total <= H_MAX) && (cfg_v_total <= V_MAX);
  end

  // Pixel/line counters; held at the frame origin while disabled.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!en) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_last) begin
      h_cnt <= '0;
      v_cnt <= v_last ? '0 : v_cnt + Y_BITS'(1);
    end else begin
      h_cnt <= h_cnt + X_BITS'(1);
    end
  end

  // Registered raster outputs decoded from the current counter position.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      hs_out      <= ~HS_POL;
      vs_out      <= ~VS_POL;
      de_out      <= 1'b0;
      x_act       <= '0;
      y_act       <= '0;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
    end else if (!en) begin
      hs_out      <= ~hs_pol;
      vs_out      <= ~vs_pol;
      de_out      <= 1'b0;
      x_act       <= '0;
      y_act       <= '0;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
    end else begin
      hs_out      <= (h_cnt < h_sync) ? hs_pol : ~hs_pol;
      vs_out      <= (v_cnt < v_sync) ? vs_pol : ~vs_pol;
      de_out      <= h_in && v_in;
      x_act       <= (h_cnt >= h_start) ? h_cnt - h_start : '0;
      y_act       <= (v_cnt >= v_start) ? v_cnt - v_start : '0;
      frame_start <= (h_cnt == '0) && (v_cnt == '0);
      line_start  <= (h_cnt == '0);
    end
  end

  // Mode handshake: the old pending mode goes live at frame end (or at once
  // while idle) before a same-cycle request refills the shadow.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      h_sync   <= X_BITS'(H_SYNC);
      h_bp     <= X_BITS'(H_BP);
      h_act    <= X_BITS'(H_ACT);
      h_fp     <= X_BITS'(H_FP);
      v_sync   <= Y_BITS'(V_SYNC);
      v_bp     <= Y_BITS'(V_BP);
      v_act    <= Y_BITS'(V_ACT);
      v_fp     <= Y_BITS'(V_FP);
      hs_pol   <= HS_POL;
      vs_pol   <= VS_POL;
      p_h_sync <= '0;
      p_h_bp   <= '0;
      p_h_act  <= '0;
      p_h_fp   <= '0;
      p_v_sync <= '0;
      p_v_bp   <= '0;
      p_v_act  <= '0;
      p_v_fp   <= '0;
      p_hs_pol <= 1'b0;
      p_vs_pol <= 1'b0;
      pend     <= 1'b0;
      cfg_ack  <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      cfg_ack <= apply;
      cfg_err <= cfg_valid && !cfg_ok;
      if (apply) begin
        h_sync <= p_h_sync;
        h_bp   <= p_h_bp;
        h_act  <= p_h_act;
        h_fp   <= p_h_fp;
        v_sync <= p_v_sync;
        v_bp   <= p_v_bp;
        v_act  <= p_v_act;
        v_fp   <= p_v_fp;
        hs_pol <= p_hs_pol;
        vs_pol <= p_vs_pol;
      end
      if (cfg_valid && cfg_ok) begin
        p_h_sync <= cfg_h_sync;
        p_h_bp   <= cfg_h_bp;
        p_h_act  <= cfg_h_act;
        p_h_fp   <= cfg_h_fp;
        p_v_sync <= cfg_v_sync;
        p_v_bp   <= cfg_v_bp;
        p_v_act  <= cfg_v_act;
        p_v_fp   <= cfg_v_fp;
        p_hs_pol <= cfg_hs_pol;
        p_vs_pol <= cfg_vs_pol;
        pend     <= 1'b1;
      end else if (apply) begin
        pend <= 1'b0;
      end
    end
  end

endmodule
